dt_param_engine: RTL and testbench
==================================

// Module: dt_param_engine
// PURPOSE
//  Parametrised two-pass distance-transform engine. Loads a packed binary image
//  from the STI ROM, expands it one pixel per RAM word, then runs a forward and
//  a backward raster pass writing each object pixel's distance to background.
//  Adds over the fixed 128x128 engine: generic image/word/distance widths, a run-time
//  metric select (chessboard / city-block), start/busy handshake, saturation.
// PARAMETERS
//  IMG_W    128  image width in pixels (>=3)
//  IMG_H    128  image height in pixels (>=3)
//  ROM_W    16   pixels per ROM word; IMG_W*IMG_H divisible by ROM_W
//  STI_AW   10   ROM address width, >= clog2(IMG_W*IMG_H/ROM_W)
//  RES_AW   14   RAM address width, >= clog2(IMG_W*IMG_H)
//  DIST_W   8    distance width; DMAX = 2**DIST_W-1
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-low
//  start     in   1       1-cycle request to process one image
//  mode      in   1       0 = chessboard (8-nbr), 1 = city-block (4-nbr); sampled at start
//  busy      out  1       high from accepted start until done cycle inclusive
//  done      out  1       1-cycle pulse when last backward write completes
//  sti_rd    out  1       ROM read strobe
//  sti_addr  out  STI_AW  ROM word address
//  sti_di    in   ROM_W   ROM data, valid combinationally for sti_addr
//  res_wr    out  1       RAM write strobe (writes res_do at res_addr this cycle)
//  res_rd    out  1       RAM read strobe
//  res_addr  out  RES_AW  RAM address = y*IMG_W + x
//  res_do    out  DIST_W  RAM write data
//  res_di    in   DIST_W  RAM read data, valid combinationally for res_addr
// BEHAVIOUR
//  Reset: state IDLE; busy, done, sti_rd, res_wr, res_rd = 0; sti_addr, res_addr, res_do = 0.
//  Reset asserted mid-operation aborts immediately; RAM contents undefined; next start restarts.
//  start accepted only in IDLE; ignored while busy. mode latched on acceptance.
//  States: IDLE -> LOAD_RD -> LOAD_WR(xROM_W) -> ... -> FWD_SCAN <-> FWD_NB -> FWD_WR
//          -> BWD_SCAN <-> BWD_NB -> BWD_WR -> DONE -> IDLE.
//  LOAD: per word, 1 LOAD_RD cycle (sti_rd=1, word captured) then ROM_W LOAD_WR cycles
//   writing pixels MSB first: pixel index = word*ROM_W + j takes bit ROM_W-1-j, res_do = 0/1.
//   Word latency ROM_W+1 cycles; after word IMG_W*IMG_H/ROM_W-1 go to FWD_SCAN.
//  Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) keep loaded value; never rewritten.
//  FWD pass: interior pixels in raster order (1,1)..(IMG_W-2,IMG_H-2). FWD_SCAN reads pixel,
//   1 cycle/pixel; zero -> next pixel; nonzero -> FWD_NB reads nbrs 1/cycle:
//   mode0 NW,N,NE,W (4 cyc); mode1 N,W (2 cyc). FWD_WR writes min(nbrs)+1.
//  BWD pass: interior pixels reverse raster from (IMG_W-2,IMG_H-2). Nonzero pixel value v
//   seeds min; BWD_NB reads mode0 E,SW,S,SE; mode1 E,S; min(v, nbr+1); BWD_WR writes it.
//  Arithmetic: nbr+1 computed in DIST_W+1 bits and saturated to DMAX; result never wraps.
//  res_rd=1 exactly in SCAN/NB cycles; res_wr=1 exactly in LOAD_WR/FWD_WR/BWD_WR cycles;
//   never both. Row wrap at x=IMG_W-2 skips border columns (address +3 fwd / -3 bwd).
//  DONE: done=1 for one cycle, busy still 1; next cycle IDLE, busy=0.
// TESTING
//  16x16, ROM_W=16, all-zero ROM -> RAM all 0; done pulse once; busy low after.
//  16x16, rows/cols 1..14 =1, border 0, mode0 -> (1,1)=1, (7,7)=7, (4,10)=4.
//  Same image but pixel (5,5)=0: mode0 -> (6,6)=1; mode1 -> (6,6)=2, (5,6)=1.
//  DIST_W=2, 32x32 all-ones interior, border 0 -> centre (15,15)=3 (DMAX), no wrap to 0.
//  start pulsed while busy -> ignored, single done; mode toggled mid-run -> no effect.
//  reset low during FWD pass -> all outputs 0 next edge; new start gives correct result.

Source files
------------

// File: rtl/dt_param_engine.sv
// rtl/dt_param_engine.sv - parametrised two-pass distance-transform engine
//
// Purpose: on a start request, unpacks a binary image from the STI ROM into
// the result RAM (one pixel per word), then runs a forward raster pass and a
// backward raster pass over the interior pixels, leaving in the RAM each
// object pixel's (saturated) distance to the background.  Metric is
// chessboard (mode=0) or city-block (mode=1), latched when start is accepted.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   start, mode    one-cycle request and metric select (sampled on accept)
//   busy, done     busy from accept through the done cycle; done one-cycle pulse
//   sti_rd         ROM read strobe, sti_addr word address, sti_di word data
//   res_wr/res_rd  RAM write/read strobes, res_addr = y*IMG_W + x
//   res_do/res_di  RAM write data / combinational read data
module dt_param_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ROM_W  = 16,
  parameter int STI_AW = 10,
  parameter int RES_AW = 14,
  parameter int DIST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [ROM_W-1:0]  sti_di,
  output logic              res_wr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int BW = (ROM_W > 1) ? $clog2(ROM_W) : 1;

  localparam logic [XW-1:0]     X_FIRST = XW'(1);
  localparam logic [XW-1:0]     X_LAST  = XW'(IMG_W - 2);
  localparam logic [YW-1:0]     Y_FIRST = YW'(1);
  localparam logic [YW-1:0]     Y_LAST  = YW'(IMG_H - 2);
  localparam logic [BW-1:0]     B_LAST  = BW'(ROM_W - 1);
  localparam logic [STI_AW-1:0] W_LAST  = STI_AW'(IMG_W * IMG_H / ROM_W - 1);

  localparam logic [RES_AW-1:0] A_ONE   = RES_AW'(1);
  localparam logic [RES_AW-1:0] A_THREE = RES_AW'(3);
  localparam logic [RES_AW-1:0] A_ROW   = RES_AW'(IMG_W);
  localparam logic [RES_AW-1:0] A_ROWM1 = RES_AW'(IMG_W - 1);
  localparam logic [RES_AW-1:0] A_ROWP1 = RES_AW'(IMG_W + 1);

  localparam logic [DIST_W-1:0] DMAX = '1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD_RD  = 4'd1;
  localparam logic [3:0] S_LOAD_WR  = 4'd2;
  localparam logic [3:0] S_FWD_SCAN = 4'd3;
  localparam logic [3:0] S_FWD_NB   = 4'd4;
  localparam logic [3:0] S_FWD_WR   = 4'd5;
  localparam logic [3:0] S_BWD_SCAN = 4'd6;
  localparam logic [3:0] S_BWD_NB   = 4'd7;
  localparam logic [3:0] S_BWD_WR   = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]        state;
  logic              mode_q;
  logic [ROM_W-1:0]  word_q;   // shifted left per pixel; MSB is the pixel being written
  logic [STI_AW-1:0] widx;
  logic [BW-1:0]     bidx;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [RES_AW-1:0] p;        // current pixel address, tracks y*IMG_W + x
  logic [1:0]        nb;
  logic [DIST_W-1:0] minv;

  logic [1:0]        nb_last;
  logic [DIST_W:0]   inc;
  logic [DIST_W-1:0] cand;
  logic              fwd_last, bwd_last;
  logic [XW-1:0]     fx, bx;
  logic [YW-1:0]     fy, by;
  logic [RES_AW-1:0] fp, bp, nb_addr;

  assign nb_last  = mode_q ? 2'd1 : 2'd3;
  // Neighbour distance plus one, saturated so a long run never wraps to 0.
  assign inc      = {1'b0, res_di} + (DIST_W+1)'(1);
  assign cand     = inc[DIST_W] ? DMAX : inc[DIST_W-1:0];
  assign fwd_last = (x == X_LAST) && (y == Y_LAST);
  assign bwd_last = (x == X_FIRST) && (y == Y_FIRST);

  // Next interior pixel in each scan direction; the row wrap hops over the
  // two border columns, hence the +/-3 address step.
  always_comb begin
    if (x == X_LAST) begin
      fx = X_FIRST;
      fy = y + YW'(1);
      fp = p + A_THREE;
    end else begin
      fx = x + XW'(1);
      fy = y;
      fp = p + A_ONE;
    end
    if (x == X_FIRST) begin
      bx = X_LAST;
      by = y - YW'(1);
      bp = p - A_THREE;
    end else begin
      bx = x - XW'(1);
      by = y;
      bp = p - A_ONE;
    end
  end

  always_comb begin
    nb_addr = p;
    if (state == S_FWD_NB) begin
      if (mode_q) begin
        nb_addr = (nb == 2'd0) ? p - A_ROW : p - A_ONE;
      end else begin
        case (nb)
          2'd0:    nb_addr = p - A_ROWP1;
          2'd1:    nb_addr = p - A_ROW;
          2'd2:    nb_addr = p - A_ROWM1;
          default: nb_addr = p - A_ONE;
        endcase
      end
    end else if (state == S_BWD_NB) begin
      if (mode_q) begin
        nb_addr = (nb == 2'd0) ? p + A_ONE : p + A_ROW;
      end else begin
        case (nb)
          2'd0:    nb_addr = p + A_ONE;
          2'd1:    nb_addr = p + A_ROWM1;
          2'd2:    nb_addr = p + A_ROW;
          default: nb_addr = p + A_ROWP1;
        endcase
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign sti_rd   = (state == S_LOAD_RD);
  assign sti_addr = sti_rd ? widx : '0;
  assign res_rd   = (state == S_FWD_SCAN) || (state == S_FWD_NB) ||
                    (state == S_BWD_SCAN) || (state == S_BWD_NB);
  assign res_wr   = (state == S_LOAD_WR) || (state == S_FWD_WR) || (state == S_BWD_WR);

  always_comb begin
    res_addr = '0;
    res_do   = '0;
    case (state)
      S_LOAD_WR: begin
        res_addr = p;
        res_do   = DIST_W'(word_q[ROM_W-1]);
      end
      S_FWD_SCAN, S_BWD_SCAN: res_addr = p;
      S_FWD_NB, S_BWD_NB:     res_addr = nb_addr;
      S_FWD_WR, S_BWD_WR: begin
        res_addr = p;
        res_do   = minv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      word_q <= '0;
      widx   <= '0;
      bidx   <= '0;
      x      <= '0;
      y      <= '0;
      p      <= '0;
      nb     <= '0;
      minv   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            widx   <= '0;
            p      <= '0;
            state  <= S_LOAD_RD;
          end
        end
        S_LOAD_RD: begin
          word_q <= sti_di;
          bidx   <= '0;
          state  <= S_LOAD_WR;
        end
        S_LOAD_WR: begin
          word_q <= word_q << 1;
          bidx   <= bidx + BW'(1);
          p      <= p + A_ONE;
          if (bidx == B_LAST) begin
            if (widx == W_LAST) begin
              x     <= X_FIRST;
              y     <= Y_FIRST;
              p     <= A_ROWP1;
              state <= S_FWD_SCAN;
            end else begin
              widx  <= widx + STI_AW'(1);
              state <= S_LOAD_RD;
            end
          end
        end
        S_FWD_SCAN: begin
          if (res_di == '0) begin
            if (fwd_last) begin
              state <= S_BWD_SCAN;
            end else begin
              x <= fx;
              y <= fy;
              p <= fp;
            end
          end else begin
            // Seed with DMAX so the result is the saturated min(nbr)+1.
            minv  <= DMAX;
            nb    <= '0;
            state <= S_FWD_NB;
          end
        end
        S_FWD_NB: begin
          if (cand < minv) minv <= cand;
          nb <= nb + 2'd1;
          if (nb == nb_last) state <= S_FWD_WR;
        end
        S_FWD_WR: begin
          if (fwd_last) begin
            state <= S_BWD_SCAN;
          end else begin
            x     <= fx;
            y     <= fy;
            p     <= fp;
            state <= S_FWD_SCAN;
          end
        end
        S_BWD_SCAN: begin
          if (res_di == '0) begin
            if (bwd_last) begin
              state <= S_DONE;
            end else begin
              x <= bx;
              y <= by;
              p <= bp;
            end
          end else begin
            minv  <= res_di;
            nb    <= '0;
            state <= S_BWD_NB;
          end
        end
        S_BWD_NB: begin
          if (cand < minv) minv <= cand;
          nb <= nb + 2'd1;
          if (nb == nb_last) state <= S_BWD_WR;
        end
        S_BWD_WR: begin
          if (bwd_last) begin
            state <= S_DONE;
          end else begin
            x     <= bx;
            y     <= by;
            p     <= bp;
            state <= S_BWD_SCAN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_param_engine.sv
// tb/tb_dt_param_engine.sv - self-checking bench for dt_param_engine
module tb_dt_param_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, mode_a, start_b, mode_b;

  // Instance A: 16x16, 8-bit distances
  logic       busy_a, done_a, sti_rd_a, res_wr_a, res_rd_a;
  logic [3:0] sti_addr_a;
  logic [15:0] sti_di_a;
  logic [7:0] res_addr_a, res_do_a, res_di_a;
  logic [15:0] rom_a [0:15];
  logic [7:0]  ram_a [0:255];

  // Instance B: 32x32, 2-bit distances (saturation)
  logic        busy_b, done_b, sti_rd_b, res_wr_b, res_rd_b;
  logic [5:0]  sti_addr_b;
  logic [15:0] sti_di_b;
  logic [9:0]  res_addr_b;
  logic [1:0]  res_do_b, res_di_b;
  logic [15:0] rom_b [0:63];
  logic [1:0]  ram_b [0:1023];

  dt_param_engine #(.IMG_W(16), .IMG_H(16), .ROM_W(16), .STI_AW(4), .RES_AW(8), .DIST_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a), .res_wr(res_wr_a),
    .res_rd(res_rd_a), .res_addr(res_addr_a), .res_do(res_do_a), .res_di(res_di_a));

  dt_param_engine #(.IMG_W(32), .IMG_H(32), .ROM_W(16), .STI_AW(6), .RES_AW(10), .DIST_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b), .res_wr(res_wr_b),
    .res_rd(res_rd_b), .res_addr(res_addr_b), .res_do(res_do_b), .res_di(res_di_b));

  assign sti_di_a = rom_a[sti_addr_a];
  assign res_di_a = ram_a[res_addr_a];
  assign sti_di_b = rom_b[sti_addr_b];
  assign res_di_b = ram_b[res_addr_b];
  always @(posedge clk) if (res_wr_a) ram_a[res_addr_a] <= res_do_a;
  always @(posedge clk) if (res_wr_b) ram_b[res_addr_b] <= res_do_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: the image, the expected final RAM, the expected write and
  // ROM-read sequences, and the expected number of busy cycles.
  int img [0:1023];
  int mdl [0:1023];
  int wq_addr[$];
  int wq_data[$];
  int rq_word[$];
  int exp_cyc;

  task automatic run_model(input int w, input int h, input int dmax, input int md);
    int nz, mn, v, p, k;
    int offs [4];
    nz = 0;
    wq_addr.delete(); wq_data.delete(); rq_word.delete();
    for (int i = 0; i < w*h/16; i++) rq_word.push_back(i);
    for (int i = 0; i < w*h; i++) begin
      mdl[i] = img[i];
      wq_addr.push_back(i);
      wq_data.push_back(img[i]);
    end
    k = md ? 2 : 4;
    if (md) begin offs[0] = -w; offs[1] = -1; offs[2] = 0; offs[3] = 0; end
    else begin offs[0] = -w-1; offs[1] = -w; offs[2] = -w+1; offs[3] = -1; end
    for (int yy = 1; yy <= h-2; yy++)
      for (int xx = 1; xx <= w-2; xx++) begin
        p = yy*w + xx;
        if (mdl[p] != 0) begin
          nz++;
          mn = dmax;
          for (int j = 0; j < k; j++) begin
            v = mdl[p+offs[j]] + 1;
            if (v > dmax) v = dmax;
            if (v < mn) mn = v;
          end
          mdl[p] = mn;
          wq_addr.push_back(p);
          wq_data.push_back(mn);
        end
      end
    if (md) begin offs[0] = 1; offs[1] = w; end
    else begin offs[0] = 1; offs[1] = w-1; offs[2] = w; offs[3] = w+1; end
    for (int yy = h-2; yy >= 1; yy--)
      for (int xx = w-2; xx >= 1; xx--) begin
        p = yy*w + xx;
        if (mdl[p] != 0) begin
          mn = mdl[p];
          for (int j = 0; j < k; j++) begin
            v = mdl[p+offs[j]] + 1;
            if (v > dmax) v = dmax;
            if (v < mn) mn = v;
          end
          mdl[p] = mn;
          wq_addr.push_back(p);
          wq_data.push_back(mn);
        end
      end
    // Object pixels stay nonzero after the forward pass, so both passes
    // visit the same number of expanded pixels.
    exp_cyc = (w*h/16)*17 + 2*(w-2)*(h-2) + 2*nz*(k+1) + 1;
  endtask

  task automatic pack_a();
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 16; j++) rom_a[k][15-j] = (img[k*16+j] != 0);
  endtask

  task automatic pack_b();
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 16; j++) rom_b[k][15-j] = (img[k*16+j] != 0);
  endtask

  task automatic fill_interior(input int w, input int h);
    for (int i = 0; i < w*h; i++)
      img[i] = ((i % w) != 0 && (i % w) != w-1 && (i / w) != 0 && (i / w) != h-1) ? 1 : 0;
  endtask

  // Per-cycle checking of instance A against the expected sequences.
  int cyc_a = 0;
  int done_cnt_a = 0;
  int qa, qd;
  always @(negedge clk) begin
    if (reset) begin
      if (start_a && !busy_a) begin
        cyc_a = 0;
        done_cnt_a = 0;
      end
      if (busy_a) cyc_a++;
      if (done_a) done_cnt_a++;
      if (res_rd_a || res_wr_a) chk("rd_wr_exclusive", int'(res_rd_a & res_wr_a), 0);
      if (sti_rd_a) begin
        if (rq_word.size() == 0) chk("sti_rd_extra", 1, 0);
        else chk("sti_addr", int'(sti_addr_a), rq_word.pop_front());
      end
      if (res_wr_a) begin
        if (wq_addr.size() == 0) chk("res_wr_extra", 1, 0);
        else begin
          qa = wq_addr.pop_front();
          qd = wq_data.pop_front();
          chk("wr_addr", int'(res_addr_a), qa);
          chk("wr_data", int'(res_do_a), qd);
        end
      end
    end
  end

  task automatic start_a_req(input logic md);
    @(posedge clk); #1;
    start_a = 1'b1; mode_a = md;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic finish_a(input string nm);
    int n, mism;
    n = 0;
    while (done_cnt_a == 0 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) chk({nm, "_timeout"}, 1, 0);
    repeat (4) @(negedge clk);
    chk({nm, "_done_count"}, done_cnt_a, 1);
    chk({nm, "_busy_after"}, int'(busy_a), 0);
    chk({nm, "_busy_cycles"}, cyc_a, exp_cyc);
    chk({nm, "_writes_left"}, wq_addr.size(), 0);
    chk({nm, "_reads_left"}, rq_word.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (int'(ram_a[i]) != mdl[i]) mism++;
    chk({nm, "_ram_mismatches"}, mism, 0);
  endtask

  task automatic run_b(input string nm, input logic md);
    int n, mism;
    @(posedge clk); #1;
    start_b = 1'b1; mode_b = md;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk({nm, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_busy_after"}, int'(busy_b), 0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (int'(ram_b[i]) != mdl[i]) mism++;
    chk({nm, "_ram_mismatches"}, mism, 0);
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    for (int i = 0; i < 16; i++) rom_a[i] = '0;
    for (int i = 0; i < 64; i++) rom_b[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_strobes", int'({sti_rd_a, res_wr_a, res_rd_a}), 0);
    chk("reset_addr_data", int'({sti_addr_a, res_addr_a, res_do_a}), 0);
    @(posedge clk); #1 reset = 1'b1;

    // All-zero image
    for (int i = 0; i < 256; i++) img[i] = 0;
    pack_a(); run_model(16, 16, 255, 0);
    start_a_req(1'b0); finish_a("zero");

    // Interior ones, chessboard
    fill_interior(16, 16);
    pack_a(); run_model(16, 16, 255, 0);
    chk("model_1_1", mdl[1*16+1], 1);
    chk("model_7_7", mdl[7*16+7], 7);
    chk("model_4_10", mdl[10*16+4], 4);
    start_a_req(1'b0); finish_a("ones_m0");
    chk("ram_1_1", int'(ram_a[1*16+1]), 1);
    chk("ram_7_7", int'(ram_a[7*16+7]), 7);
    chk("ram_4_10", int'(ram_a[10*16+4]), 4);

    // Hole at (5,5), chessboard; start pulses and mode toggles while busy
    img[5*16+5] = 0;
    pack_a(); run_model(16, 16, 255, 0);
    chk("model_hole_m0_6_6", mdl[6*16+6], 1);
    start_a_req(1'b0);
    repeat (40) @(posedge clk);
    #1 start_a = 1'b1; mode_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (400) begin @(posedge clk); #1 mode_a = ~mode_a; end
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    finish_a("hole_m0");
    chk("ram_hole_m0_6_6", int'(ram_a[6*16+6]), 1);

    // Same image, city-block
    run_model(16, 16, 255, 1);
    chk("model_hole_m1_6_6", mdl[6*16+6], 2);
    chk("model_hole_m1_5_6", mdl[6*16+5], 1);
    start_a_req(1'b1); finish_a("hole_m1");
    chk("ram_hole_m1_6_6", int'(ram_a[6*16+6]), 2);
    chk("ram_hole_m1_5_6", int'(ram_a[6*16+5]), 1);

    // Random images, random metric, borders included
    for (int t = 0; t < 6; t++) begin
      int dens, md;
      dens = $urandom_range(30, 95);
      md = $urandom_range(0, 1);
      for (int i = 0; i < 256; i++) img[i] = ($urandom_range(0, 99) < dens) ? 1 : 0;
      pack_a(); run_model(16, 16, 255, md);
      start_a_req(md[0]); finish_a($sformatf("rand%0d", t));
    end

    // Reset during the forward pass, then a clean rerun
    fill_interior(16, 16);
    img[3*16+9] = 0;
    pack_a(); run_model(16, 16, 255, 0);
    start_a_req(1'b0);
    repeat (300) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_strobes", int'({sti_rd_a, res_wr_a, res_rd_a}), 0);
    chk("abort_addr_data", int'({sti_addr_a, res_addr_a, res_do_a}), 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    run_model(16, 16, 255, 0);
    start_a_req(1'b0); finish_a("after_abort");

    // Saturation on the 2-bit instance
    fill_interior(32, 32);
    pack_b(); run_model(32, 32, 3, 0);
    chk("model_sat_15_15", mdl[15*32+15], 3);
    run_b("sat_m0", 1'b0);
    chk("ram_sat_15_15", int'(ram_b[15*32+15]), 3);
    chk("ram_sat_2_2", int'(ram_b[2*32+2]), 2);
    run_model(32, 32, 3, 1);
    run_b("sat_m1", 1'b1);
    chk("ram_sat_m1_15_15", int'(ram_b[15*32+15]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
